// File: rtl/seq_pkg.sv
// ============================================================================
//  Module   : seq_pkg
//  Brief    : Shared event/frame types for the sequencer UART event path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    // One queued key event: rotary pitch in the high nibble, key index low.
    typedef struct packed {
        logic [3:0] pitch;
        logic [3:0] step;
    } seq_event_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        GAP  = 3'd4
    } frame_state_t;

    // Frame header byte; the host-side decoder keys on the same value.
    localparam logic [7:0] SEQ_SYNC_BYTE = 8'hA5;

    // Checksum byte closing a frame.
    function automatic logic [7:0] frame_checksum(input logic [7:0] sync_byte,
                                                  input seq_event_t ev);
        return sync_byte ^ ev;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO, first-word fall-through read, pointer-wrap
//             full/empty detection using an extra pointer MSB.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    // A push into a full FIFO is allowed when a pop frees the slot this cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign level   = r_wr_ptr - r_rd_ptr;
    assign rd_data = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

    // Pointer advance on push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_event_framer.sv
// ============================================================================
//  Module   : uart_event_framer
//  Brief    : Turns each debounced key press into one 3-byte UART frame
//             (SYNC, {pitch,index}, checksum) through a small event queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_event_framer
    import seq_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 4,
    parameter int         HOLDOFF_CYCLES = 120_000,
    parameter logic [7:0] SYNC_BYTE      = SEQ_SYNC_BYTE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          button_pressed,
    input  logic [3:0]                    button_index,
    input  logic [3:0]                    rotary_position,
    input  logic                          tx_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    overflow_count
);

    localparam int c_HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [c_HO_W-1:0] c_HO_LOAD = c_HO_W'(HOLDOFF_CYCLES - 1);

    logic              r_prev;
    logic [c_HO_W-1:0] r_holdoff;
    logic [7:0]        r_ovf;
    logic              w_rise;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_hs;
    seq_event_t        w_wr_event;
    seq_event_t        w_rd_event;
    seq_event_t        r_payload;
    frame_state_t      r_state;
    frame_state_t      w_state_nxt;
    frame_state_t      r_ret;
    frame_state_t      w_ret_nxt;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic              w_tx_valid_nxt;
    logic [7:0]        w_tx_data_nxt;

    assign w_rise     = button_pressed & ~r_prev;
    assign w_accept   = w_rise & (r_holdoff == '0);
    assign w_push     = w_accept & (~w_fifo_full | w_pop);
    assign w_wr_event = '{pitch: rotary_position, step: button_index};
    assign w_hs       = r_tx_valid & tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (w_wr_event),
        .rd_data (w_rd_event),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .level   (fifo_level)
    );

    // Edge detect and post-edge holdoff window that swallows contact bounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev    <= 1'b0;
            r_holdoff <= '0;
        end else begin
            r_prev <= button_pressed;
            if (w_accept)              r_holdoff <= c_HO_LOAD;
            else if (r_holdoff != '0)  r_holdoff <= r_holdoff - 1'b1;
        end
    end

    // Saturating count of accepted events lost to a full queue.
    always_ff @(posedge clk) begin
        if (rst)                                                   r_ovf <= 8'd0;
        else if (w_accept && w_fifo_full && !w_pop && r_ovf != 8'hFF) r_ovf <= r_ovf + 8'd1;
    end

    // Frame sequencing; tx outputs are precomputed from the next state so they are registered.
    always_comb begin
        w_state_nxt    = r_state;
        w_ret_nxt      = r_ret;
        w_pop          = 1'b0;
        w_tx_valid_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        case (r_state)
            IDLE: if (!w_fifo_empty) begin w_pop = 1'b1; w_state_nxt = SYNC; end
            SYNC: if (w_hs) begin w_state_nxt = GAP; w_ret_nxt = DATA; end
            DATA: if (w_hs) begin w_state_nxt = GAP; w_ret_nxt = CSUM; end
            CSUM: if (w_hs) begin w_state_nxt = GAP; w_ret_nxt = IDLE; end
            GAP:  w_state_nxt = r_ret;
            default: w_state_nxt = IDLE;
        endcase
        case (w_state_nxt)
            SYNC: begin w_tx_valid_nxt = 1'b1; w_tx_data_nxt = SYNC_BYTE; end
            DATA: begin w_tx_valid_nxt = 1'b1; w_tx_data_nxt = r_payload; end
            CSUM: begin w_tx_valid_nxt = 1'b1; w_tx_data_nxt = frame_checksum(SYNC_BYTE, r_payload); end
            default: ;
        endcase
    end

    // FSM, payload and registered tx outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ret      <= IDLE;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'd0;
            r_payload  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ret      <= w_ret_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_data  <= w_tx_data_nxt;
            if (w_pop) r_payload <= w_rd_event;
        end
    end

    assign tx_valid       = r_tx_valid;
    assign tx_data        = r_tx_data;
    assign overflow_count = r_ovf;
    assign busy           = (r_state != IDLE) | (fifo_level != '0);

endmodule

`default_nettype wire

// File: tb/tb_uart_event_framer.sv
// ============================================================================
//  Module   : tb_uart_event_framer
//  Brief    : Directed self-checking bench for uart_event_framer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_event_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       button_pressed = 1'b0;
    logic [3:0] button_index = 4'h0;
    logic [3:0] rotary_position = 4'h0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic [2:0] fifo_level;
    logic [7:0] overflow_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] bytes_q [$];
    int         stamp_q [$];

    uart_event_framer #(
        .FIFO_DEPTH     (4),
        .HOLDOFF_CYCLES (16),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .button_pressed  (button_pressed),
        .button_index    (button_index),
        .rotary_position (rotary_position),
        .tx_ready        (tx_ready),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .busy            (busy),
        .fifo_level      (fifo_level),
        .overflow_count  (overflow_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            bytes_q.push_back(tx_data);
            stamp_q.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0)       begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00)       begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (busy !== 1'b0)           begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (fifo_level !== 3'd0)     begin n_fail++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
        n_cmp++; if (overflow_count !== 8'd0) begin n_fail++; $display("FAIL reset_overflow: got %0d want 0", overflow_count); end
    endtask

    task automatic test_single_frame;
        automatic logic [7:0] exp_b [3] = '{8'hA5, 8'h37, 8'h92};
        bytes_q.delete(); stamp_q.delete();
        tx_ready = 1'b1; rotary_position = 4'h3; button_index = 4'h7;
        tick(1);
        button_pressed = 1'b1;
        tick(1);
        n_cmp++; if (tx_valid !== 1'b0)   begin n_fail++; $display("FAIL single_lat_valid_early: got %b want 0", tx_valid); end
        n_cmp++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_lat_level: got %0d want 1", fifo_level); end
        tick(1);
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5)
            begin n_fail++; $display("FAIL single_lat_sync: got valid=%b data=%h want 1/a5", tx_valid, tx_data); end
        tick(38);
        button_pressed = 1'b0;
        tick(20);
        n_cmp++;
        if (bytes_q.size() != 3) begin
            n_fail++; $display("FAIL single_count: got %0d bytes want 3", bytes_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (bytes_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h want %h", i, bytes_q[i], exp_b[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                n_cmp++; if (stamp_q[i] - stamp_q[i-1] != 2) begin n_fail++; $display("FAIL single_gap%0d: got %0d cycles want 2", i, stamp_q[i] - stamp_q[i-1]); end
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_bounce;
        automatic logic [7:0] exp_b [3] = '{8'hA5, 8'h52, 8'hF7};
        bytes_q.delete(); stamp_q.delete();
        rotary_position = 4'h5; button_index = 4'h2;
        button_pressed = 1'b1; tick(1);
        button_pressed = 1'b0; tick(1);
        button_pressed = 1'b1; tick(1);
        button_pressed = 1'b0; tick(1);
        button_pressed = 1'b1; tick(3);
        button_pressed = 1'b0;
        tick(30);
        n_cmp++;
        if (bytes_q.size() != 3) begin
            n_fail++; $display("FAIL bounce_count: got %0d bytes want 3", bytes_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (bytes_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL bounce_byte%0d: got %h want %h", i, bytes_q[i], exp_b[i]); end
            end
        end
        n_cmp++; if (overflow_count !== 8'd0) begin n_fail++; $display("FAIL bounce_overflow: got %0d want 0", overflow_count); end
    endtask

    // An initial press (idx E) parks the FSM in SYNC so six more presses see a stalled queue.
    // Afterwards a seventh press lands exactly on the cycle IDLE pops a full FIFO.
    task automatic test_overflow_and_full_pop;
        automatic logic [7:0] exp_b [18] = '{8'hA5, 8'h1E, 8'hBB,
                                             8'hA5, 8'h10, 8'hB5,
                                             8'hA5, 8'h11, 8'hB4,
                                             8'hA5, 8'h12, 8'hB7,
                                             8'hA5, 8'h13, 8'hB6,
                                             8'hA5, 8'h16, 8'hB3};
        bytes_q.delete(); stamp_q.delete();
        tx_ready = 1'b0; rotary_position = 4'h1; button_index = 4'hE;
        button_pressed = 1'b1; tick(2);
        button_pressed = 1'b0; tick(18);
        for (int k = 0; k < 6; k++) begin
            button_index = 4'(k);
            button_pressed = 1'b1; tick(2);
            button_pressed = 1'b0; tick(18);
        end
        n_cmp++; if (fifo_level !== 3'd4)     begin n_fail++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        n_cmp++; if (overflow_count !== 8'd2) begin n_fail++; $display("FAIL ovf_count: got %0d want 2", overflow_count); end
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5)
            begin n_fail++; $display("FAIL ovf_stalled_sync: got valid=%b data=%h want 1/a5", tx_valid, tx_data); end
        n_cmp++; if (busy !== 1'b1)           begin n_fail++; $display("FAIL ovf_busy: got %b want 1", busy); end
        // Frame E drains in six edges; the seventh edge is IDLE's pop.
        tx_ready = 1'b1;
        tick(6);
        n_cmp++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fullpop_pre_level: got %0d want 4", fifo_level); end
        button_index = 4'h6; button_pressed = 1'b1;
        tick(1);
        n_cmp++; if (fifo_level !== 3'd4)     begin n_fail++; $display("FAIL fullpop_level: got %0d want 4", fifo_level); end
        n_cmp++; if (overflow_count !== 8'd2) begin n_fail++; $display("FAIL fullpop_overflow: got %0d want 2", overflow_count); end
        tick(1);
        button_pressed = 1'b0;
        tick(70);
        n_cmp++;
        if (bytes_q.size() != 18) begin
            n_fail++; $display("FAIL drain_count: got %0d bytes want 18", bytes_q.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                n_cmp++; if (bytes_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL drain_byte%0d: got %h want %h", i, bytes_q[i], exp_b[i]); end
            end
        end
        n_cmp++; if (busy !== 1'b0 || fifo_level !== 3'd0)
            begin n_fail++; $display("FAIL drain_idle: got busy=%b level=%0d want 0/0", busy, fifo_level); end
    endtask

    task automatic test_stall_data;
        automatic logic [7:0] exp_b [3] = '{8'hA5, 8'h94, 8'h31};
        automatic bit stable_ok = 1'b1;
        bytes_q.delete(); stamp_q.delete();
        tx_ready = 1'b1; rotary_position = 4'h9; button_index = 4'h4;
        tick(1);
        button_pressed = 1'b1;
        tick(3);
        tx_ready = 1'b0; button_pressed = 1'b0;
        tick(1);
        for (int i = 0; i < 50; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h94) stable_ok = 1'b0;
            tick(1);
        end
        n_cmp++; if (stable_ok !== 1'b1) begin n_fail++; $display("FAIL stall_stable: got %b want 1 (last valid=%b data=%h)", stable_ok, tx_valid, tx_data); end
        tx_ready = 1'b1;
        tick(10);
        n_cmp++;
        if (bytes_q.size() != 3) begin
            n_fail++; $display("FAIL stall_count: got %0d bytes want 3", bytes_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (bytes_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, bytes_q[i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        automatic logic [7:0] exp_b [3] = '{8'hA5, 8'h28, 8'h8D};
        bytes_q.delete(); stamp_q.delete();
        tx_ready = 1'b1; rotary_position = 4'h2; button_index = 4'h8;
        tick(1);
        button_pressed = 1'b1;
        tick(1);
        button_pressed = 1'b0;
        tick(5);
        n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 8'h8D)
            begin n_fail++; $display("FAIL rstmid_in_csum: got valid=%b data=%h want 1/8d", tx_valid, tx_data); end
        tx_ready = 1'b0; rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0)   begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", tx_valid); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (bytes_q.size() != 2) begin n_fail++; $display("FAIL rstmid_partial: got %0d bytes want 2", bytes_q.size()); end
        bytes_q.delete(); stamp_q.delete();
        tx_ready = 1'b1;
        tick(1);
        button_pressed = 1'b1;
        tick(2);
        button_pressed = 1'b0;
        tick(20);
        n_cmp++;
        if (bytes_q.size() != 3) begin
            n_fail++; $display("FAIL rstmid_after_count: got %0d bytes want 3", bytes_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (bytes_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL rstmid_after_byte%0d: got %h want %h", i, bytes_q[i], exp_b[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_bounce();
        test_overflow_and_full_pop();
        test_stall_data();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
